hazard_unit_mc: RTL and testbench
=================================

# hazard_unit_mc

Parametrised, stateful successor to the pipeline hazard unit for the 5-stage core (F/D/E/M/W). It keeps EX-stage forwarding and branch flushing, and adds three things:

- multi-cycle load-use stalls, for memories slower than one bubble;
- a register scoreboard for the long-latency mul/div unit, covering RAW, WAW and structural hazards;
- a saturating stall-cycle performance counter.

It sits beside the pipeline registers and drives their stall/flush enables and the EX operand muxes.

## Interface
Parameters:
- AW, 5, register-address width; NUM_REGS = 2**AW
- LOAD_USE_CYCLES, 1, bubbles inserted per load-use hazard (legal 1..4)
- CNT_W, 16, width of the stall performance counter

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- Rs1D, Rs2D, RdD  in  AW  decode-stage source/destination registers
- RegWriteD  in  1  decode instruction writes RdD
- MdOpD  in  1  decode instruction is mul/div
- Rs1E, Rs2E, RdE  in  AW  execute-stage registers
- RegWriteE  in  1  execute instruction writes RdE
- ResultSrcE  in  2  01 = load
- PCSRCE  in  1  taken branch/jump resolved in E
- MdStartE  in  1  mul/div issues from E this cycle (destination RdE)
- MdBusy  in  1  mul/div unit occupied
- MdDone  in  1  mul/div writes MdRd this cycle
- MdRd  in  AW  mul/div writeback register
- RdM, RdW  in  AW; RegWriteM, RegWriteW  in  1  later-stage writers
- StallF, StallD, FlushD, FlushE  out  1  pipeline controls
- Forward_AE, Forward_BE  out  2  00 regfile, 10 from M, 01 from W
- Pending  out  NUM_REGS  scoreboard (debug)
- StallCycles  out  CNT_W  saturating count of cycles with StallD=1

## Operation
Forwarding (combinational):
- For each of Rs1E/Rs2E: M match (RegWriteM, Rs != 0) → 10; else W match (RegWriteW, Rs != 0) → 01; else 00. M has priority over W.

Scoreboard:
- Pending[r] is set at the clock edge when MdStartE && RdE != 0 && r == RdE.
- Pending[r] is cleared when MdDone && MdRd == r.
- If set and clear hit the same register in one cycle, set wins.
- Bit 0 is never set.
- Effective pending = Pending & ~(MdDone ? onehot(MdRd) : 0). The regfile is write-through, so a completing register is readable in D the same cycle.

Stall sources, each asserting StallF = StallD = FlushE = 1:
- load: FSM below;
- RAW: Rs1D or Rs2D is effectively pending, or equals RdE while MdStartE (RdE != 0);
- WAW: RegWriteD && RdD != 0 && RdD effectively pending;
- structural: MdOpD && (MdBusy || MdStartE).

Load FSM, states IDLE and LSTALL with counter cnt (3 bits):
- Detection: ResultSrcE == 01 && RegWriteE && RdE != 0 && (Rs1D == RdE || Rs2D == RdE).
- IDLE: detection stalls this cycle. If LOAD_USE_CYCLES > 1, go to LSTALL with cnt = LOAD_USE_CYCLES-1.
- LSTALL: stall asserted every cycle. cnt decrements; when cnt == 1, return to IDLE.

Branch priority:
- PCSRCE forces FlushD = FlushE = 1 and StallF = StallD = 0, overriding every stall source.
- PCSRCE in LSTALL returns the FSM to IDLE with cnt = 0.
- PCSRCE does not modify the scoreboard, because issued mul/div ops complete architecturally.

StallCycles increments each cycle with StallD = 1 and saturates at all-ones.

## Timing
- Reset (async assert, sync-safe deassert): Pending = 0, FSM = IDLE, cnt = 0, StallCycles = 0. While rst_n is low, all control outputs and Forward_* are forced to 0.
- Forwarding and stall/flush outputs are combinational from inputs and registered state; zero added latency.
- Scoreboard updates are visible from the cycle after MdStartE. The same-cycle case is covered by the RdE comparison.
- A load-use hazard produces exactly LOAD_USE_CYCLES consecutive stall cycles unless cut short by PCSRCE.
- Reset mid-stall aborts immediately: FSM goes to IDLE and scoreboard is cleared.

## Test plan
- Forwarding: RdM = RdW = Rs1E = 3, both writes set → Forward_AE = 10. Drop RegWriteM → 01. Rs1E = 0 → 00.
- Load-use, LOAD_USE_CYCLES = 2: load RdE = 5, Rs2D = 5 → StallF/StallD/FlushE high for exactly 2 cycles; StallCycles = 2.
- Branch during LSTALL: PCSRCE in the second stall cycle → StallF = 0, FlushD = FlushE = 1; next cycle IDLE, no stall.
- Scoreboard RAW:
  - MdStartE with RdE = 7 → Pending[7] = 1 next cycle.
  - Rs1D = 7 stalls until MdDone with MdRd = 7; no stall in that completion cycle.
  - Pending[7] = 0 after the completion cycle.
- Scoreboard WAW and structural: Pending[9] set with RegWriteD, RdD = 9 → stall. MdOpD while MdBusy → stall. Simultaneous MdStartE (RdE = 4) and MdDone (MdRd = 4) → Pending[4] stays 1.
- Reset mid-stall, then counter saturation: assert rst_n = 0 in LSTALL → outputs 0, Pending = 0. With CNT_W = 4, hold a stall for 20 cycles → StallCycles = 15.

Source files
------------

// File: rtl/hazard_unit_mc.sv
//==============================================================================
// Module   : hazard_unit_mc
// Purpose  : Stateful hazard unit for the 5-stage core. EX forwarding, branch
//            flushing, multi-cycle load-use stalls, a mul/div register
//            scoreboard (RAW/WAW/structural) and a saturating stall counter.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module hazard_unit_mc #(
    parameter int AW              = 5,
    parameter int LOAD_USE_CYCLES = 1,
    parameter int CNT_W           = 16,
    localparam int NUM_REGS       = 2**AW
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [AW-1:0]       Rs1D,
    input  logic [AW-1:0]       Rs2D,
    input  logic [AW-1:0]       RdD,
    input  logic                RegWriteD,
    input  logic                MdOpD,
    input  logic [AW-1:0]       Rs1E,
    input  logic [AW-1:0]       Rs2E,
    input  logic [AW-1:0]       RdE,
    input  logic                RegWriteE,
    input  logic [1:0]          ResultSrcE,
    input  logic                PCSRCE,
    input  logic                MdStartE,
    input  logic                MdBusy,
    input  logic                MdDone,
    input  logic [AW-1:0]       MdRd,
    input  logic [AW-1:0]       RdM,
    input  logic [AW-1:0]       RdW,
    input  logic                RegWriteM,
    input  logic                RegWriteW,
    output logic                StallF,
    output logic                StallD,
    output logic                FlushD,
    output logic                FlushE,
    output logic [1:0]          Forward_AE,
    output logic [1:0]          Forward_BE,
    output logic [NUM_REGS-1:0] Pending,
    output logic [CNT_W-1:0]    StallCycles
);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_LSTALL = 1'b1;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_M  = 2'b10;
    localparam logic [1:0] FWD_W  = 2'b01;

    localparam logic [2:0]       LSTALL_INIT = 3'(LOAD_USE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

    logic [0:0]          state, state_nxt;
    logic [2:0]          cnt, cnt_nxt;
    logic [NUM_REGS-1:0] sb_set, sb_clr, eff_pending;
    logic                load_detect, load_stall;
    logic                raw_stall, waw_stall, struct_stall, any_stall;
    logic [1:0]          fwd_a, fwd_b;

    // Scoreboard set/clear masks; register 0 can never become pending
    always_comb begin
        sb_set = '0;
        sb_clr = '0;
        if (MdStartE && (RdE != '0))
            sb_set[RdE] = 1'b1;
        if (MdDone)
            sb_clr[MdRd] = 1'b1;
    end

    // Write-through regfile: a completing register is already readable in D
    assign eff_pending = Pending & ~sb_clr;

    // Scoreboard register; a same-cycle set beats the clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            Pending <= '0;
        else
            Pending <= (Pending & ~sb_clr) | sb_set;
    end

    assign load_detect = (ResultSrcE == 2'b01) && RegWriteE && (RdE != '0) &&
                         ((Rs1D == RdE) || (Rs2D == RdE));

    // Load FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= 3'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Load FSM next state; a taken branch flushes the load, so never stay stalled
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: begin
                if (load_detect && !PCSRCE && (LOAD_USE_CYCLES > 1)) begin
                    state_nxt = S_LSTALL;
                    cnt_nxt   = LSTALL_INIT;
                end
            end
            S_LSTALL: begin
                if (PCSRCE || (cnt == 3'd1)) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = 3'd0;
                end else begin
                    cnt_nxt = cnt - 3'd1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = 3'd0;
            end
        endcase
    end

    // Load FSM output: stall on first detection and throughout LSTALL
    always_comb begin
        load_stall = 1'b0;
        case (state)
            S_IDLE:   load_stall = load_detect;
            S_LSTALL: load_stall = 1'b1;
            default:  load_stall = 1'b0;
        endcase
    end

    assign raw_stall = eff_pending[Rs1D] || eff_pending[Rs2D] ||
                       (MdStartE && (RdE != '0) && ((Rs1D == RdE) || (Rs2D == RdE)));
    assign waw_stall    = RegWriteD && (RdD != '0) && eff_pending[RdD];
    assign struct_stall = MdOpD && (MdBusy || MdStartE);
    assign any_stall    = load_stall || raw_stall || waw_stall || struct_stall;

    // Forwarding select; the younger M-stage result wins over W
    always_comb begin
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
        if (RegWriteM && (Rs1E != '0) && (Rs1E == RdM))      fwd_a = FWD_M;
        else if (RegWriteW && (Rs1E != '0) && (Rs1E == RdW)) fwd_a = FWD_W;
        if (RegWriteM && (Rs2E != '0) && (Rs2E == RdM))      fwd_b = FWD_M;
        else if (RegWriteW && (Rs2E != '0) && (Rs2E == RdW)) fwd_b = FWD_W;
    end

    // Control outputs; a taken branch overrides every stall, reset forces all low
    always_comb begin
        StallF     = rst_n && any_stall && !PCSRCE;
        StallD     = rst_n && any_stall && !PCSRCE;
        FlushD     = rst_n && PCSRCE;
        FlushE     = rst_n && (any_stall || PCSRCE);
        Forward_AE = rst_n ? fwd_a : FWD_RF;
        Forward_BE = rst_n ? fwd_b : FWD_RF;
    end

    // Saturating count of decode-stall cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            StallCycles <= '0;
        else if (StallD && (StallCycles != CNT_MAX))
            StallCycles <= StallCycles + 1'b1;
    end

endmodule

`default_nettype wire

// File: tb/tb_hazard_unit_mc.sv
//==============================================================================
// Module   : tb_hazard_unit_mc
// Purpose  : Self-checking bench for hazard_unit_mc (LOAD_USE_CYCLES=2, CNT_W=4)
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_hazard_unit_mc;

    localparam int AW = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [AW-1:0] Rs1D, Rs2D, RdD, Rs1E, Rs2E, RdE, MdRd, RdM, RdW;
    logic RegWriteD, MdOpD, RegWriteE, PCSRCE, MdStartE, MdBusy, MdDone;
    logic RegWriteM, RegWriteW;
    logic [1:0] ResultSrcE;
    logic StallF, StallD, FlushD, FlushE;
    logic [1:0] Forward_AE, Forward_BE;
    logic [31:0] Pending;
    logic [3:0] StallCycles;

    int n_chk = 0;
    int n_fail = 0;

    hazard_unit_mc #(.AW(AW), .LOAD_USE_CYCLES(2), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .RegWriteD(RegWriteD), .MdOpD(MdOpD),
        .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RegWriteE(RegWriteE),
        .ResultSrcE(ResultSrcE), .PCSRCE(PCSRCE), .MdStartE(MdStartE),
        .MdBusy(MdBusy), .MdDone(MdDone), .MdRd(MdRd),
        .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .Forward_AE(Forward_AE), .Forward_BE(Forward_BE),
        .Pending(Pending), .StallCycles(StallCycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rs1e, rs2e, rdm, rdw;
        logic       regwm, regww;
        logic [4:0] rs1d, rs2d, rdd;
        logic       regwd, mdopd;
        logic [4:0] rde;
        logic       regwe;
        logic [1:0] rsrc;
        logic       pcsrc, mdstart, mdbusy;
        logic [1:0] ea, eb;
        logic       estall, eflushd, eflushe;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        Rs1D = '0; Rs2D = '0; RdD = '0; Rs1E = '0; Rs2E = '0; RdE = '0;
        MdRd = '0; RdM = '0; RdW = '0;
        RegWriteD = 0; MdOpD = 0; RegWriteE = 0; PCSRCE = 0; MdStartE = 0;
        MdBusy = 0; MdDone = 0; RegWriteM = 0; RegWriteW = 0; ResultSrcE = 2'b00;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Advance to just after the next rising edge, where inputs are driven
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ctl(input string name, input logic stall, input logic fd, input logic fe);
        chk({name, ".StallF"}, StallF, stall);
        chk({name, ".StallD"}, StallD, stall);
        chk({name, ".FlushD"}, FlushD, fd);
        chk({name, ".FlushE"}, FlushE, fe);
    endtask

    initial begin
        //          rs1e rs2e rdm rdw wm ww rs1d rs2d rdd wd op rde we src pc st by  ea    eb    s  fd fe
        vecs[0]  = '{3, 0, 3, 3, 1, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 2'b10, 2'b00, 0, 0, 0};
        vecs[1]  = '{3, 0, 3, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 2'b01, 2'b00, 0, 0, 0};
        vecs[2]  = '{0, 0, 3, 3, 1, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0};
        vecs[3]  = '{0, 6, 6, 6, 1, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 2'b00, 2'b10, 0, 0, 0};
        vecs[4]  = '{0, 6, 2, 6, 1, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 2'b00, 2'b01, 0, 0, 0};
        vecs[5]  = '{0, 0, 0, 0, 0, 0, 0, 5, 0, 0, 0, 5, 1, 2'b01, 0, 0, 0, 2'b00, 2'b00, 1, 0, 1};
        vecs[6]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b01, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0};
        vecs[7]  = '{0, 0, 0, 0, 0, 0, 5, 0, 0, 0, 0, 5, 1, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0};
        vecs[8]  = '{0, 0, 0, 0, 0, 0, 0, 5, 0, 0, 0, 5, 1, 2'b01, 1, 0, 0, 2'b00, 2'b00, 0, 1, 1};
        vecs[9]  = '{0, 0, 0, 0, 0, 0, 8, 0, 0, 0, 0, 8, 1, 2'b00, 0, 1, 0, 2'b00, 2'b00, 1, 0, 1};
        vecs[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 0, 0, 1, 2'b00, 2'b00, 1, 0, 1};
        vecs[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 0, 1, 0, 2'b00, 2'b00, 1, 0, 1};
        vecs[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0, 0, 2'b00, 2'b00, 0, 1, 1};
        vecs[13] = '{0, 0, 0, 0, 0, 0, 0, 5, 0, 0, 0, 5, 0, 2'b01, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0};
        vecs[14] = '{0, 0, 0, 0, 0, 0, 5, 0, 0, 0, 0, 5, 1, 2'b10, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0};
        vecs[15] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 1, 0, 2'b00, 2'b00, 0, 0, 0};
        vecs[16] = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0};

        clear_inputs();
        #12;
        chk("reset.StallF", StallF, 0);
        chk("reset.FlushE", FlushE, 0);
        chk("reset.Pending", Pending, 0);
        chk("reset.StallCycles", StallCycles, 0);
        do_reset();

        // Table vectors are only present between edges, so state never moves
        for (int i = 0; i < 17; i++) begin
            step();
            Rs1E = vecs[i].rs1e; Rs2E = vecs[i].rs2e; RdM = vecs[i].rdm; RdW = vecs[i].rdw;
            RegWriteM = vecs[i].regwm; RegWriteW = vecs[i].regww;
            Rs1D = vecs[i].rs1d; Rs2D = vecs[i].rs2d; RdD = vecs[i].rdd;
            RegWriteD = vecs[i].regwd; MdOpD = vecs[i].mdopd; RdE = vecs[i].rde;
            RegWriteE = vecs[i].regwe; ResultSrcE = vecs[i].rsrc; PCSRCE = vecs[i].pcsrc;
            MdStartE = vecs[i].mdstart; MdBusy = vecs[i].mdbusy;
            @(negedge clk);
            chk($sformatf("vec%0d.Forward_AE", i), Forward_AE, vecs[i].ea);
            chk($sformatf("vec%0d.Forward_BE", i), Forward_BE, vecs[i].eb);
            chk_ctl($sformatf("vec%0d", i), vecs[i].estall, vecs[i].eflushd, vecs[i].eflushe);
            #1;
            clear_inputs();
        end
        chk("table.Pending", Pending, 0);
        chk("table.StallCycles", StallCycles, 0);

        // Load-use: exactly two stall cycles
        do_reset();
        step();
        ResultSrcE = 2'b01; RegWriteE = 1; RdE = 5; Rs2D = 5;
        @(negedge clk); chk_ctl("lu.c1", 1, 0, 1);
        step();
        ResultSrcE = 2'b00; RegWriteE = 0; RdE = 0;
        @(negedge clk); chk_ctl("lu.c2", 1, 0, 1);
        step();
        @(negedge clk); chk_ctl("lu.c3", 0, 0, 0);
        chk("lu.StallCycles", StallCycles, 2);

        // Taken branch in the second stall cycle
        do_reset();
        step();
        ResultSrcE = 2'b01; RegWriteE = 1; RdE = 5; Rs2D = 5;
        @(negedge clk); chk_ctl("br.c1", 1, 0, 1);
        step();
        ResultSrcE = 2'b00; RegWriteE = 0; RdE = 0; PCSRCE = 1;
        @(negedge clk); chk_ctl("br.c2", 0, 1, 1);
        step();
        PCSRCE = 0;
        @(negedge clk); chk_ctl("br.c3", 0, 0, 0);

        // Scoreboard RAW through completion
        do_reset();
        step();
        MdStartE = 1; RdE = 7;
        step();
        MdStartE = 0; RdE = 0;
        chk("raw.Pending7", Pending[7], 1);
        Rs1D = 7;
        @(negedge clk); chk_ctl("raw.wait1", 1, 0, 1);
        step();
        @(negedge clk); chk_ctl("raw.wait2", 1, 0, 1);
        step();
        MdDone = 1; MdRd = 7;
        @(negedge clk); chk_ctl("raw.done", 0, 0, 0);
        step();
        MdDone = 0; MdRd = 0;
        chk("raw.Pending7_clr", Pending[7], 0);
        @(negedge clk); chk_ctl("raw.after", 0, 0, 0);

        // WAW, set-beats-clear, register zero never pending
        do_reset();
        step();
        MdStartE = 1; RdE = 9;
        step();
        RdE = 4; RegWriteD = 1; RdD = 9;
        @(negedge clk); chk_ctl("waw", 1, 0, 1);
        step();
        RegWriteD = 0; RdD = 0; MdDone = 1; MdRd = 4;
        step();
        MdDone = 0; MdRd = 0; RdE = 0;
        chk("sb.set_wins", Pending, 32'h0000_0210);
        step();
        MdStartE = 0;
        chk("sb.reg0", Pending, 32'h0000_0210);
        RegWriteD = 1; RdD = 4;
        @(negedge clk); chk_ctl("waw4", 1, 0, 1);
        #1; RegWriteD = 0; RdD = 0;

        // Reset in the middle of a load stall
        do_reset();
        step();
        MdStartE = 1; RdE = 9;
        step();
        MdStartE = 0; ResultSrcE = 2'b01; RegWriteE = 1; RdE = 5; Rs1D = 5;
        step();
        clear_inputs();
        #1; chk("rst.pre_stall", StallD, 1);
        Rs1E = 3; RdM = 3; RegWriteM = 1; MdOpD = 1; MdBusy = 1; PCSRCE = 1;
        #1; rst_n = 1'b0;
        #1;
        chk_ctl("rst.mid", 0, 0, 0);
        chk("rst.Forward_AE", Forward_AE, 0);
        chk("rst.Pending", Pending, 0);
        chk("rst.StallCycles", StallCycles, 0);
        clear_inputs();
        @(negedge clk); rst_n = 1'b1;
        step();
        @(negedge clk); chk_ctl("rst.idle", 0, 0, 0);

        // Counter saturation with a held structural stall
        do_reset();
        step();
        MdOpD = 1; MdBusy = 1;
        for (int i = 0; i < 15; i++) @(posedge clk);
        @(negedge clk); chk("sat.15", StallCycles, 15);
        for (int i = 0; i < 5; i++) @(posedge clk);
        @(negedge clk); chk("sat.20", StallCycles, 15);
        clear_inputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
